// File: rtl/two_bit_seq_generator.sv
// Purpose : serialise a 1..16 bit pattern, repeated reps+1 times, as MSB-first bit pairs.
// Latency : first pair valid the cycle after the accepted start edge; one pair per cycle while ready=1.
// Backpres: ready=0 holds data/data_vld unchanged; start is ignored while busy.
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   start              begin a transmission (sampled only when busy=0, ignored if len=0)
//   pattern[15:0]      active bits pattern[len-1:0], pattern[len-1] sent first
//   len[4:0]           pattern length 1..16
//   reps[3:0]          pattern is sent reps+1 times
//   ready              sink accepts the current pair this cycle
//   data[1:0]          data[1] = earlier bit, data[0] = later bit (0 pad on odd tail)
//   data_vld           data holds a valid pair
//   busy               FSM not IDLE
//   done               single-cycle completion pulse
module two_bit_seq_generator (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] pattern,
  input  logic [4:0]  len,
  input  logic [3:0]  reps,
  input  logic        ready,
  output logic [1:0]  data,
  output logic        data_vld,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] FIN  = 2'd2;

  logic [1:0]  state;
  logic [15:0] pat_q;
  logic [3:0]  lm1_q;   // len-1: the wrap target of the bit index
  logic [3:0]  idx_q;   // index of the next bit not yet placed on data
  logic [8:0]  rem_q;   // bits not yet placed on data (the repetition count lives here)

  // The next pair is built either from the live inputs (first pair, at the
  // start edge) or from the latched copies (subsequent pairs), so the first
  // pair can be registered straight onto data without a bubble.
  logic [15:0] src_pat;
  logic [3:0]  src_lm1;
  logic [3:0]  cur_idx;
  logic [8:0]  cur_rem;
  logic [3:0]  idx_a;
  logic [3:0]  idx_n;
  logic [8:0]  rem_n;
  logic        bit_hi;
  logic        bit_lo;
  logic        two_left;

  always_comb begin
    src_pat = pat_q;
    src_lm1 = lm1_q;
    cur_idx = idx_q;
    cur_rem = rem_q;
    if (state == IDLE) begin
      src_pat = pattern;
      src_lm1 = len[3:0] - 4'd1;      // len=16 wraps to 15 in 4 bits
      cur_idx = len[3:0] - 4'd1;
      cur_rem = {4'd0, len} * ({5'd0, reps} + 9'd1);  // max 16*16 = 256 fits in 9 bits
    end
    two_left = (cur_rem >= 9'd2);
    bit_hi   = src_pat[cur_idx];
    // Index wraps to len-1 after bit 0; each wrap starts the next repetition.
    idx_a    = (cur_idx == 4'd0) ? src_lm1 : cur_idx - 4'd1;
    bit_lo   = two_left ? src_pat[idx_a] : 1'b0;
    idx_n    = (idx_a == 4'd0) ? src_lm1 : idx_a - 4'd1;
    rem_n    = two_left ? cur_rem - 9'd2 : 9'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pat_q    <= '0;
      lm1_q    <= '0;
      idx_q    <= '0;
      rem_q    <= '0;
      data     <= 2'b00;
      data_vld <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          data     <= 2'b00;
          data_vld <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
          if (start && (len != 5'd0)) begin
            state    <= SEND;
            pat_q    <= pattern;
            lm1_q    <= len[3:0] - 4'd1;
            idx_q    <= idx_n;
            rem_q    <= rem_n;
            data     <= {bit_hi, bit_lo};
            data_vld <= 1'b1;
            busy     <= 1'b1;
          end
        end
        SEND: begin
          if (ready) begin
            if (rem_q == 9'd0) begin
              // Final pair just transferred.
              state    <= FIN;
              data     <= 2'b00;
              data_vld <= 1'b0;
              done     <= 1'b1;
            end else begin
              idx_q <= idx_n;
              rem_q <= rem_n;
              data  <= {bit_hi, bit_lo};
            end
          end
        end
        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          data     <= 2'b00;
          data_vld <= 1'b0;
          busy     <= 1'b0;
          done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_two_bit_seq_generator.sv
module tb_two_bit_seq_generator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] pattern;
  logic [4:0]  len;
  logic [3:0]  reps;
  logic        ready;
  logic [1:0]  data;
  logic        data_vld;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Observed vector: {data_vld, busy, done, data}
  localparam logic [4:0] V_IDLE = 5'b00000;
  localparam logic [4:0] V_FIN  = 5'b01100;

  two_bit_seq_generator dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .pattern  (pattern),
    .len      (len),
    .reps     (reps),
    .ready    (ready),
    .data     (data),
    .data_vld (data_vld),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [4:0] exp);
    logic [4:0] obs;
    obs = {data_vld, busy, done, data};
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed={vld,busy,done,data}=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Check a shown pair, then let it transfer (ready assumed 1).
  task automatic pair(input string tag, input logic [1:0] d);
    chk(tag, {3'b110, d});
    tick();
  endtask

  task automatic go(input logic [15:0] p, input logic [4:0] l, input logic [3:0] r);
    pattern = p;
    len     = l;
    reps    = r;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  initial begin
    logic [15:0] pa;
    rst_n   = 1'b0;
    start   = 1'b0;
    pattern = '0;
    len     = '0;
    reps    = '0;
    ready   = 1'b1;
    #1;
    chk("reset_async", V_IDLE);
    tick();
    tick();
    chk("reset_held", V_IDLE);
    rst_n = 1'b1;

    // Basic: 0x59, len 7, one pass -> 10 11 00 10(pad)
    go(16'h0059, 5'd7, 4'd0);
    pair("b_p0", 2'b10);
    pair("b_p1", 2'b11);
    pair("b_p2", 2'b00);
    pair("b_p3", 2'b10);
    chk("b_fin", V_FIN);
    tick();
    chk("b_idle", V_IDLE);

    // Two repetitions, boundaries fall inside pairs
    go(16'h0059, 5'd7, 4'd1);
    pair("r_p0", 2'b10);
    pair("r_p1", 2'b11);
    pair("r_p2", 2'b00);
    pair("r_p3", 2'b11);
    pair("r_p4", 2'b01);
    pair("r_p5", 2'b10);
    pair("r_p6", 2'b01);
    chk("r_fin", V_FIN);
    tick();
    chk("r_idle", V_IDLE);

    // Backpressure on the second pair for 3 cycles
    go(16'h0059, 5'd7, 4'd0);
    pair("h_p0", 2'b10);
    ready = 1'b0;
    chk("h_hold0", 5'b11011);
    tick();
    chk("h_hold1", 5'b11011);
    tick();
    chk("h_hold2", 5'b11011);
    ready = 1'b1;
    tick();
    pair("h_p2", 2'b00);
    pair("h_p3", 2'b10);
    chk("h_fin", V_FIN);
    tick();
    chk("h_idle", V_IDLE);

    // start with len=0 is ignored
    go(16'hFFFF, 5'd0, 4'd3);
    chk("z_idle0", V_IDLE);
    tick();
    chk("z_idle1", V_IDLE);

    // start during SEND with different inputs has no effect
    go(16'h0059, 5'd7, 4'd0);
    pattern = 16'hFFFF;
    len     = 5'd16;
    reps    = 4'd3;
    start   = 1'b1;
    pair("s_p0", 2'b10);
    pair("s_p1", 2'b11);
    start   = 1'b0;
    pair("s_p2", 2'b00);
    pair("s_p3", 2'b10);
    chk("s_fin", V_FIN);
    tick();
    chk("s_idle", V_IDLE);

    // len=1, three passes: 1 1 1 -> 11, 10(pad)
    go(16'h0001, 5'd1, 4'd2);
    pair("o_p0", 2'b11);
    pair("o_p1", 2'b10);
    chk("o_fin", V_FIN);
    tick();

    // Maximum: 16 bits x 16 passes = 128 pairs
    pa = 16'hA5C3;
    go(pa, 5'd16, 4'd15);
    for (int k = 0; k < 128; k++) begin
      int j;
      j = k % 8;
      pair($sformatf("m_p%0d", k), {pa[15 - 2*j], pa[14 - 2*j]});
    end
    chk("m_fin", V_FIN);
    tick();
    chk("m_idle", V_IDLE);

    // Reset mid-SEND after two transfers
    go(16'h0059, 5'd7, 4'd0);
    pair("x_p0", 2'b10);
    pair("x_p1", 2'b11);
    chk("x_p2", 5'b11000);
    rst_n = 1'b0;
    #1;
    chk("x_rst_async", V_IDLE);
    tick();
    chk("x_rst_nodone", V_IDLE);
    rst_n = 1'b1;
    go(16'h0059, 5'd7, 4'd0);
    pair("x2_p0", 2'b10);
    pair("x2_p1", 2'b11);
    pair("x2_p2", 2'b00);
    pair("x2_p3", 2'b10);
    chk("x2_fin", V_FIN);
    tick();
    chk("x2_idle", V_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
